mult_sched: RTL and testbench
=============================

Name: mult_sched

Overview:
Shares one combinational signed WIDTH x WIDTH multiplier (the existing mult block) between NREQ requesters. Round-robin arbitration picks one request, registers its operands, captures the product one cycle later and presents it with the requester ID on a valid/ready response port. One transaction is in flight at a time. The block sits between requester front-ends and the multiplier datapath.

Parameters:
WIDTH, 6, operand width in bits (two's complement); product is 2*WIDTH bits.
NREQ, 4, number of requesters (2..16).
IDW, 2, response ID width; must be >= clog2(NREQ).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  NREQ  bit i = requester i has operands pending
req_ready  output  NREQ  one-hot grant; bit i high = requester i accepted this cycle
req_x  input  NREQ*WIDTH  packed multiplicands; requester i at [i*WIDTH +: WIDTH]
req_y  input  NREQ*WIDTH  packed multipliers, same packing
rsp_valid  output  1  result valid
rsp_ready  input  1  consumer accepts result
rsp_id  output  IDW  index of requester owning the result
rsp_z  output  2*WIDTH  signed product x*y
busy  output  1  high in any state other than IDLE
done_cnt  output  16  completed responses, saturating at 16'hFFFF

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_z=0, busy=0, done_cnt=0. Operand registers cleared.
- FSM states: IDLE, CALC, RESP.
- IDLE: if any req_valid, grant g = first set bit at or after rr_ptr, wrapping from NREQ-1 to 0. req_ready[g]=1 combinationally in the same cycle and no other bit is set. On the clock edge: latch req_x/req_y slice g into op_x/op_y, latch g into id_r, set rr_ptr=(g+1) mod NREQ, go to CALC. With no req_valid: stay in IDLE, req_ready=0, rr_ptr unchanged.
- req_ready is 0 in CALC and RESP. Requesters hold valid and operands until they see ready.
- CALC: mult(op_x, op_y) settles. On the edge: rsp_z <= product, rsp_id <= id_r, rsp_valid <= 1, go to RESP.
- RESP: hold rsp_valid, rsp_z and rsp_id stable while rsp_ready=0, with no timeout. When rsp_valid&&rsp_ready: on the edge rsp_valid <= 0, done_cnt increments (saturating), go to IDLE. No new grant is issued in the RESP cycle.
- Latency: grant in cycle T -> rsp_valid in T+2. Minimum issue interval is 3 cycles (rsp_ready tied high).
- Arithmetic: full signed product with no truncation. -2^(W-1) * -2^(W-1) = +2^(2W-2) is representable.
- Fairness: with all requesters continuously valid, grants cycle 0,1,...,NREQ-1,0. No requester waits more than NREQ transactions.
- req_valid that drops while not granted: the request is simply not seen. It is not a protocol error.
- rsp_ready asserted outside RESP: ignored.
- Reset mid-operation: the in-flight transaction is discarded with no response and done_cnt returns to 0.
- busy = (state != IDLE).

Test Plan:
1. Reset, then req_valid=0001, x0=6'b110110 (-10), y0=6'b101011 (-21), rsp_ready=1 -> req_ready=0001 in the grant cycle; two cycles later rsp_valid=1, rsp_z=12'h0D2 (210), rsp_id=0; done_cnt=1.
2. Corner values: x=-32, y=-32 -> rsp_z=12'h400. x=31, y=-32 -> rsp_z=12'hC20 (-992). x=0, y=-1 -> 12'h000.
3. req_valid=1111 held, each requester with distinct operands, rsp_ready=1 -> grants in order 0,1,2,3,0; rsp_id follows the same order; grants are 3 cycles apart; products are correct.
4. Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_z and rsp_id stable, req_ready=0 throughout, busy=1; on rsp_ready=1, one handshake occurs and done_cnt increments by exactly 1.
5. rr_ptr=2 (after granting requester 1), req_valid=0011 -> requester 0 granted (wrap), not requester 1.
6. Assert rst_n=0 in CALC -> all outputs return to reset values immediately (asynchronously), no rsp_valid afterwards; next request is granted from rr_ptr=0.

Source files
------------

// File: rtl/mult_sched.sv
// rtl/mult_sched.sv - round-robin scheduler sharing one signed multiplier among requesters
module mult_sched #(
  parameter int WIDTH = 6,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_x,
  input  logic [NREQ*WIDTH-1:0]   req_y,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [2*WIDTH-1:0]      rsp_z,
  output logic                    busy,
  output logic [15:0]             done_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state;
  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     id_r;
  logic [WIDTH-1:0]   op_x;
  logic [WIDTH-1:0]   op_y;

  logic               gnt_any;
  logic [IDW-1:0]     gnt_idx;
  logic [WIDTH-1:0]   sel_x;
  logic [WIDTH-1:0]   sel_y;
  logic [IDW:0]       cand_sum;
  logic [2*WIDTH-1:0] prod;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping at NREQ
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    cand_sum = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand_sum = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (cand_sum >= (IDW+1)'(NREQ)) begin
        cand_sum = cand_sum - (IDW+1)'(NREQ);
      end
      if (!gnt_any && req_valid[cand_sum[IDW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand_sum[IDW-1:0];
      end
    end
  end

  // Operand mux and one-hot ready, only offered while idle
  always_comb begin
    sel_x     = '0;
    sel_y     = '0;
    req_ready = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_idx == IDW'(k)) begin
        sel_x = req_x[k*WIDTH +: WIDTH];
        sel_y = req_y[k*WIDTH +: WIDTH];
        req_ready[k] = (state == IDLE) && gnt_any;
      end
    end
  end

  // Shared multiplier: sign-extend both operands so the 2W-bit product is exact
  assign prod = {{WIDTH{op_x[WIDTH-1]}}, op_x} * {{WIDTH{op_y[WIDTH-1]}}, op_y};

  assign busy = (state != IDLE);

  // Scheduler FSM: grant and latch operands, capture product, hold response until accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      id_r      <= '0;
      op_x      <= '0;
      op_y      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_z     <= '0;
      done_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            op_x   <= sel_x;
            op_y   <= sel_y;
            id_r   <= gnt_idx;
            rr_ptr <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);
            state  <= CALC;
          end
        end
        CALC: begin
          rsp_z     <= prod;
          rsp_id    <= id_r;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (done_cnt != 16'hFFFF) begin
              done_cnt <= done_cnt + 16'd1;
            end
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_sched.sv
// tb/tb_mult_sched.sv - self-checking bench for mult_sched with a transaction-level model
module tb_mult_sched;
  localparam int W   = 6;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_x;
  logic [N*W-1:0]   req_y;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [IDW-1:0]   rsp_id;
  logic [2*W-1:0]   rsp_z;
  logic             busy;
  logic [15:0]      done_cnt;

  int errors = 0;
  int checks = 0;

  // model state: one outstanding transaction and the round-robin pointer
  int          m_rr, m_pend, m_age, m_id, m_done, cyc;
  logic [11:0] m_z;
  int          glog_id[$];
  int          glog_cyc[$];

  always #5 clk = ~clk;

  mult_sched #(.WIDTH(W), .NREQ(N), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_z     (rsp_z),
    .busy      (busy),
    .done_cnt  (done_cnt)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int rr);
    for (int k = 0; k < N; k++) begin
      if (v[(rr + k) % N]) return (rr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [11:0] sprod(input logic [W-1:0] a, input logic [W-1:0] b);
    int ia;
    int ib;
    ia = $signed(a);
    ib = $signed(b);
    return 12'(ia * ib);
  endfunction

  task automatic model_reset();
    m_rr = 0; m_pend = 0; m_age = 0; m_id = 0; m_done = 0; m_z = '0;
  endtask

  // model: compare on the falling edge, advance on the rising edge
  initial begin
    int g;
    logic [N-1:0] er;
    model_reset();
    cyc = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done_cnt", done_cnt, 0);
        check("rst_rsp_z", rsp_z, 0);
      end else begin
        er = '0;
        if (m_pend == 0) begin
          g = pick(req_valid, m_rr);
          if (g >= 0) er = N'(1) << g;
        end
        check("req_ready", req_ready, er);
        check("busy", busy, m_pend);
        check("rsp_valid", rsp_valid, (m_pend != 0 && m_age >= 2) ? 1 : 0);
        if (m_pend != 0 && m_age >= 2) begin
          check("rsp_z", rsp_z, m_z);
          check("rsp_id", rsp_id, m_id);
        end
        check("done_cnt", done_cnt, m_done);
      end
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        model_reset();
      end else if (m_pend == 0) begin
        g = pick(req_valid, m_rr);
        if (g >= 0) begin
          m_pend = 1;
          m_age  = 1;
          m_id   = g;
          m_z    = sprod(req_x[g*W +: W], req_y[g*W +: W]);
          m_rr   = (g + 1) % N;
          glog_id.push_back(g);
          glog_cyc.push_back(cyc);
        end
      end else if (m_age == 1) begin
        m_age = 2;
      end else if (rsp_ready) begin
        m_pend = 0;
        if (m_done < 65535) m_done++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (rsp_valid) break;
    end
  endtask

  task automatic set_ops(input int i, input int x, input int y);
    req_x[i*W +: W] = x[W-1:0];
    req_y[i*W +: W] = y[W-1:0];
  endtask

  task automatic do_txn(input int i, input int x, input int y, input int ez);
    int n;
    set_ops(i, x, y);
    req_valid = N'(1) << i;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("grant", req_ready, 1 << i);
    tick();
    req_valid = '0;
    wait_rsp(n);
    check("latency", n, 2);
    check("lit_rsp_z", rsp_z, ez);
    check("lit_rsp_id", rsp_id, i);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; req_valid = '0; req_x = '0; req_y = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_z", rsp_z, 0);
    check("reset_rsp_id", rsp_id, 0);
    check("reset_done", done_cnt, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // basic product
    do_txn(0, -10, -21, 12'h0D2);
    @(negedge clk);
    check("done_after_first", done_cnt, 1);
    tick();

    // corner values
    do_txn(1, -32, -32, 12'h400);
    do_txn(2, 31, -32, 12'hC20);
    do_txn(3, 0, -1, 12'h000);

    // all requesters valid: round-robin order and 3-cycle spacing
    glog_id.delete();
    glog_cyc.delete();
    for (int i = 0; i < N; i++) set_ops(i, i*9 - 13, 11 - 7*i);
    req_valid = '1;
    rsp_ready = 1'b1;
    repeat (13) tick();
    req_valid = '0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 10);
    check("rr_idle_reached", busy, 0);
    check("rr_grant_count", glog_id.size(), 5);
    if (glog_id.size() >= 5) begin
      for (int k = 0; k < 5; k++) check("rr_order", glog_id[k], k % N);
      for (int k = 1; k < 5; k++) check("rr_spacing", glog_cyc[k] - glog_cyc[k-1], 3);
    end
    check("done_after_rr", done_cnt, 9);
    tick();

    // backpressure on the response port
    set_ops(3, -7, 9);
    req_valid = 4'b1000;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_grant", req_ready, 8);
    tick();
    req_valid = 4'b0001;
    wait_rsp(n);
    check("bp_latency", n, 2);
    for (int k = 0; k < 5; k++) begin
      if (k != 0) begin
        @(posedge clk);
        #1;
        @(negedge clk);
      end
      check("bp_rsp_z", rsp_z, 12'hFC1);
      check("bp_rsp_id", rsp_id, 3);
      check("bp_req_ready", req_ready, 0);
      check("bp_busy", busy, 1);
      check("bp_rsp_valid", rsp_valid, 1);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    req_valid = '0;
    @(negedge clk);
    check("bp_done_before", done_cnt, 9);
    tick();
    @(negedge clk);
    check("bp_done_after", done_cnt, 10);
    check("bp_valid_dropped", rsp_valid, 0);
    tick();

    // wrap: after granting requester 1 the pointer is 2, so 0011 grants requester 0
    do_txn(1, 3, 3, 9);
    set_ops(0, -1, -1);
    req_valid = 4'b0011;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("wrap_grant", req_ready, 1);
    tick();
    req_valid = '0;
    wait_rsp(n);
    check("wrap_rsp_id", rsp_id, 0);
    check("wrap_rsp_z", rsp_z, 1);
    tick();
    @(negedge clk);
    check("done_after_wrap", done_cnt, 12);
    tick();

    // reset while the product is being computed
    set_ops(2, 5, 5);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_req_ready", req_ready, 0);
    check("mid_rst_done", done_cnt, 0);
    check("mid_rst_rsp_z", rsp_z, 0);
    check("mid_rst_rsp_id", rsp_id, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_no_rsp", rsp_valid, 0);
      tick();
    end
    req_valid = '1;
    @(negedge clk);
    check("post_rst_grant", req_ready, 1);
    tick();
    req_valid = '0;
    wait_rsp(n);
    check("post_rst_latency", n, 2);
    check("post_rst_rsp_id", rsp_id, 0);
    check("post_rst_rsp_z", rsp_z, 1);
    tick();
    @(negedge clk);
    check("post_rst_done", done_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
